// File: rtl/demux16b4_pkg.sv
// Shared constants for the registered 1-to-4 word distributor.
package demux16b4_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

endpackage

// File: rtl/demux16b4_out_slot.sv
// One-entry destination register with valid/ready; a load on the drain edge
// keeps the slot full so each slot sustains one word per cycle.
module out_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             can_load
);

    assign can_load = !valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= data;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux16b4_reg.sv
// Registered 1-to-4 distributor: routes I to slot A..D chosen by S, with
// per-slot back-pressure and a sticky flag for sources that drop a stalled word.
module demux16b4_reg
    import demux16b4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] I,
    input  logic [1:0]       S,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       O_VALID,
    input  logic [3:0]       O_READY,
    output logic             ERR
);

    logic [3:0]       can_load;
    logic [3:0]       load;
    logic [WIDTH-1:0] q [4];
    logic             accept_p0;
    logic             stall_p0;
    logic             stall_p1;
    logic [WIDTH-1:0] i_p1;
    logic [1:0]       s_p1;
    logic             viol;

    assign I_READY   = can_load[S];
    assign accept_p0 = I_VALID & I_READY;

    always_comb begin
        load    = '0;
        load[S] = accept_p0;
    end

    for (genvar k = 0; k < 4; k++) begin : g_slot
        out_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (CLK),
            .rst_n    (RST_N),
            .load     (load[k]),
            .data     (I),
            .ready    (O_READY[k]),
            .q        (q[k]),
            .valid    (O_VALID[k]),
            .can_load (can_load[k])
        );
    end

    assign A = q[SEL_A];
    assign B = q[SEL_B];
    assign C = q[SEL_C];
    assign D = q[SEL_D];

    // p0 -> p1: remember a stalled offer so the next cycle can confirm it was held
    assign stall_p0 = I_VALID & !I_READY;
    assign viol     = stall_p1 & (!I_VALID | (I != i_p1) | (S != s_p1));

    always_ff @(posedge CLK) begin
        i_p1 <= I;
        s_p1 <= S;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_p1 <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            stall_p1 <= stall_p0;
            if (viol) begin
                ERR <= 1'b1;
            end
        end
    end

endmodule
